// File: rtl/quad_step_decoder_pkg.sv
// Shared types and phase helpers for the quadrature step decoder.
package quad_pkg;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Forward (A leads B) Gray-code successor of a filtered {A,B} phase.
    function automatic logic [1:0] next_fwd(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_step_decoder_filter.sv
// Input synchroniser followed by a level filter: a new synced level must
// hold for FILT_LEN consecutive cycles before it appears on o_dout.
module glitch_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned FILT_W      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_W-1:0]      r_cnt;
    logic                   r_filt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_dout   = r_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    // Counter restarts whenever the synced level agrees with the accepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_synced == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == FILT_W'(FILT_LEN - 1)) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + FILT_W'(1);
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// x4 quadrature decoder: filtered A/B phases in, one-cycle up/down strobes
// out, with a sticky flag for skipped (two-bit) transitions.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned FILT_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       en,
    input  logic       clr_err,
    output logic       up,
    output logic       down,
    output logic       err,
    output logic [1:0] phase,
    output logic       valid
);

    logic              w_a_filt;
    logic              w_b_filt;
    logic [1:0]        w_filt;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FILT_W-1:0] r_init_cnt;
    logic [FILT_W-1:0] w_init_cnt_nxt;
    logic [1:0]        r_phase;
    logic [1:0]        w_phase_nxt;
    logic              r_up;
    logic              r_down;
    logic              r_err;
    logic              r_valid;
    logic              w_up_nxt;
    logic              w_down_nxt;
    logic              w_err_nxt;
    logic              w_valid_nxt;

    glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .FILT_W      (FILT_W)
    ) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .i_din  (a_in),
        .o_dout (w_a_filt)
    );

    glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .FILT_W      (FILT_W)
    ) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .i_din  (b_in),
        .o_dout (w_b_filt)
    );

    assign w_filt = {w_a_filt, w_b_filt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_phase    <= PH_00;
            r_up       <= 1'b0;
            r_down     <= 1'b0;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_up       <= w_up_nxt;
            r_down     <= w_down_nxt;
            r_err      <= w_err_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    // Illegal transition sets err in the same cycle a clear is requested: set wins.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_phase_nxt    = r_phase;
        w_valid_nxt    = r_valid;
        w_up_nxt       = 1'b0;
        w_down_nxt     = 1'b0;
        w_err_nxt      = r_err & ~clr_err;

        case (r_state)
            S_INIT: begin
                if (r_init_cnt == FILT_W'(FILT_LEN - 1)) begin
                    w_phase_nxt    = w_filt;
                    w_valid_nxt    = 1'b1;
                    w_init_cnt_nxt = '0;
                    w_state_nxt    = S_TRACK;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + FILT_W'(1);
                end
            end
            S_TRACK: begin
                if (w_filt != r_phase) begin
                    w_phase_nxt = w_filt;
                    if (w_filt == next_fwd(r_phase)) begin
                        w_up_nxt = en;
                    end else if (r_phase == next_fwd(w_filt)) begin
                        w_down_nxt = en;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    assign up    = r_up;
    assign down  = r_down;
    assign err   = r_err;
    assign phase = r_phase;
    assign valid = r_valid;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (SYNC_STAGES=2, FILT_LEN=4, 4-bit step counter model).
module tb_quad_step_decoder;

    logic       clk;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       en;
    logic       clr_err;
    logic       up;
    logic       down;
    logic       err;
    logic [1:0] phase;
    logic       valid;

    int         vec_cnt;
    int         miss_cnt;
    int         up_cnt;
    int         down_cnt;
    int         bad_cnt;
    logic [3:0] ctr4;
    logic       prev_up;
    logic       prev_down;

    quad_step_decoder #(
        .SYNC_STAGES (2),
        .FILT_LEN    (4),
        .FILT_W      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .en      (en),
        .clr_err (clr_err),
        .up      (up),
        .down    (down),
        .err     (err),
        .phase   (phase),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock, sampled 1ns after the edge; tallies strobes into the step counter model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (up === 1'b1) begin
            up_cnt++;
            ctr4 = ctr4 + 4'd1;
        end
        if (down === 1'b1) begin
            down_cnt++;
            ctr4 = ctr4 - 4'd1;
        end
        if ((up === 1'b1 && down === 1'b1) || (up === 1'b1 && prev_up === 1'b1) ||
            (down === 1'b1 && prev_down === 1'b1))
            bad_cnt++;
        prev_up   = up;
        prev_down = down;
    endtask

    task automatic clear_tallies();
        up_cnt   = 0;
        down_cnt = 0;
        bad_cnt  = 0;
        ctr4     = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if ({up, down, err, valid} !== 4'b0000) begin
            miss_cnt++;
            $display("FAIL reset_outs: got up/down/err/valid=%b want 0000", {up, down, err, valid});
        end
        vec_cnt++;
        if (phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL reset_phase: got %b want 00", phase);
        end
        rst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 3) begin
                vec_cnt++;
                if (valid !== 1'b0) begin
                    miss_cnt++;
                    $display("FAIL init_valid_early: got %b want 0", valid);
                end
            end
        end
        vec_cnt++;
        if (valid !== 1'b1) begin
            miss_cnt++;
            $display("FAIL init_valid: got %b want 1", valid);
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [8];
        seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        clear_tallies();
        for (int s = 0; s < 8; s++) begin
            {a_in, b_in} = seq[s];
            for (int t = 1; t <= 8; t++) begin
                tick();
                if (t == 6 || t == 8) begin
                    vec_cnt++;
                    if (up !== 1'b0) begin
                        miss_cnt++;
                        $display("FAIL fwd_up_off step %0d t%0d: got %b want 0", s, t, up);
                    end
                end else if (t == 7) begin
                    vec_cnt++;
                    if (up !== 1'b1) begin
                        miss_cnt++;
                        $display("FAIL fwd_up_on step %0d: got %b want 1", s, up);
                    end
                end
            end
            vec_cnt++;
            if (phase !== seq[s]) begin
                miss_cnt++;
                $display("FAIL fwd_phase step %0d: got %b want %b", s, phase, seq[s]);
            end
        end
        vec_cnt++;
        if (up_cnt != 8 || down_cnt != 0 || bad_cnt != 0) begin
            miss_cnt++;
            $display("FAIL fwd_counts: got up=%0d down=%0d bad=%0d want 8 0 0", up_cnt, down_cnt, bad_cnt);
        end
        vec_cnt++;
        if (ctr4 !== 4'd8) begin
            miss_cnt++;
            $display("FAIL fwd_counter: got %0d want 8", ctr4);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] seq [8];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        clear_tallies();
        for (int s = 0; s < 8; s++) begin
            {a_in, b_in} = seq[s];
            for (int t = 1; t <= 8; t++) begin
                tick();
                if (t == 7) begin
                    vec_cnt++;
                    if (down !== 1'b1) begin
                        miss_cnt++;
                        $display("FAIL rev_down_on step %0d: got %b want 1", s, down);
                    end
                end
            end
            if (s == 0) begin
                vec_cnt++;
                if (ctr4 !== 4'd15) begin
                    miss_cnt++;
                    $display("FAIL rev_wrap: got %0d want 15", ctr4);
                end
            end
        end
        vec_cnt++;
        if (up_cnt != 0 || down_cnt != 8 || bad_cnt != 0) begin
            miss_cnt++;
            $display("FAIL rev_counts: got up=%0d down=%0d bad=%0d want 0 8 0", up_cnt, down_cnt, bad_cnt);
        end
        vec_cnt++;
        if (ctr4 !== 4'd8 || phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL rev_final: got ctr=%0d phase=%b want 8 00", ctr4, phase);
        end
    endtask

    task automatic test_glitch();
        clear_tallies();
        a_in = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) a_in = 1'b0;
        end
        vec_cnt++;
        if (up_cnt != 0 || down_cnt != 0 || phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL glitch3: got up=%0d down=%0d phase=%b want 0 0 00", up_cnt, down_cnt, phase);
        end
        a_in = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 4) a_in = 1'b0;
            if (t == 7) begin
                vec_cnt++;
                if (up !== 1'b1) begin
                    miss_cnt++;
                    $display("FAIL glitch4_up: got %b want 1", up);
                end
            end
            if (t == 11) begin
                vec_cnt++;
                if (down !== 1'b1) begin
                    miss_cnt++;
                    $display("FAIL glitch4_down: got %b want 1", down);
                end
            end
        end
        vec_cnt++;
        if (up_cnt != 1 || down_cnt != 1 || phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL glitch4_counts: got up=%0d down=%0d phase=%b want 1 1 00", up_cnt, down_cnt, phase);
        end
    endtask

    task automatic test_illegal();
        clear_tallies();
        {a_in, b_in} = 2'b11;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 6) begin
                vec_cnt++;
                if (err !== 1'b0) begin
                    miss_cnt++;
                    $display("FAIL jump_err_early: got %b want 0", err);
                end
            end
        end
        vec_cnt++;
        if (err !== 1'b1 || phase !== 2'b11 || up_cnt != 0 || down_cnt != 0) begin
            miss_cnt++;
            $display("FAIL jump_err: got err=%b phase=%b up=%0d down=%0d want 1 11 0 0",
                     err, phase, up_cnt, down_cnt);
        end
        {a_in, b_in} = 2'b00;
        for (int t = 1; t <= 8; t++) begin
            if (t == 7) clr_err = 1'b1;
            tick();
            clr_err = 1'b0;
        end
        vec_cnt++;
        if (err !== 1'b1 || phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL clr_vs_set: got err=%b phase=%b want 1 00", err, phase);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        vec_cnt++;
        if (err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL clr_err: got %b want 0", err);
        end
        vec_cnt++;
        if (up_cnt != 0 || down_cnt != 0) begin
            miss_cnt++;
            $display("FAIL jump_strobes: got up=%0d down=%0d want 0 0", up_cnt, down_cnt);
        end
    endtask

    task automatic test_enable();
        logic [1:0] seq [3];
        seq = '{2'b10, 2'b11, 2'b01};
        clear_tallies();
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            {a_in, b_in} = seq[s];
            for (int t = 1; t <= 8; t++) tick();
        end
        vec_cnt++;
        if (up_cnt != 0 || down_cnt != 0 || phase !== 2'b01) begin
            miss_cnt++;
            $display("FAIL en_off: got up=%0d down=%0d phase=%b want 0 0 01", up_cnt, down_cnt, phase);
        end
        en = 1'b1;
        {a_in, b_in} = 2'b00;
        for (int t = 1; t <= 10; t++) tick();
        vec_cnt++;
        if (up_cnt != 1 || down_cnt != 0 || err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL en_on: got up=%0d down=%0d err=%b want 1 0 0", up_cnt, down_cnt, err);
        end
    endtask

    task automatic test_mid_reset();
        clear_tallies();
        a_in = 1'b1;
        for (int t = 1; t <= 6; t++) tick();
        vec_cnt++;
        if (valid !== 1'b1) begin
            miss_cnt++;
            $display("FAIL pre_reset_valid: got %b want 1", valid);
        end
        #2;
        rst  = 1'b1;
        a_in = 1'b0;
        #1;
        vec_cnt++;
        if ({up, down, err, valid} !== 4'b0000 || phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL mid_reset: got up/down/err/valid=%b phase=%b want 0000 00",
                     {up, down, err, valid}, phase);
        end
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 4; t++) tick();
        vec_cnt++;
        if (valid !== 1'b1 || phase !== 2'b00) begin
            miss_cnt++;
            $display("FAIL reinit: got valid=%b phase=%b want 1 00", valid, phase);
        end
        for (int t = 1; t <= 10; t++) tick();
        vec_cnt++;
        if (up_cnt != 0 || down_cnt != 0 || err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reinit_strobes: got up=%0d down=%0d err=%b want 0 0 0", up_cnt, down_cnt, err);
        end
    endtask

    initial begin
        vec_cnt   = 0;
        miss_cnt  = 0;
        prev_up   = 1'b0;
        prev_down = 1'b0;
        rst       = 1'b1;
        a_in      = 1'b0;
        b_in      = 1'b0;
        en        = 1'b1;
        clr_err   = 1'b0;
        clear_tallies();

        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_enable();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
